// File: rtl/decodificador_fases_motor.sv
// Stepper phase monitor: decodes the six driver lines, tracks half-step position, flags faults.
// Latency 2 cycles from line change to STEP/POSITION/flags; no backpressure, samples every cycle.
module decodificador_fases_motor #(
    parameter int POS_WIDTH   = 16,
    parameter int STALL_LIMIT = 50000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 A,
    input  logic                 B,
    input  logic                 C,
    input  logic                 D,
    input  logic                 INH1,
    input  logic                 INH2,
    input  logic                 CLR_POS,
    input  logic                 ERR_CLR,
    output logic [2:0]           PHASE,
    output logic                 PHASE_VALID,
    output logic                 STEP,
    output logic                 DIR,
    output logic                 HALF,
    output logic [POS_WIDTH-1:0] POSITION,
    output logic                 ERR_ILLEGAL,
    output logic                 ERR_SKIP,
    output logic                 STALLED
);

    localparam int CNT_W = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_LIMIT);

    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_TRACK   = 1'b1
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [5:0]           pat_q;
    logic [2:0]           prev_idx;
    logic [2:0]           prev_idx_n;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     stall_cnt_n;

    logic                 legal;
    logic [2:0]           idx;
    logic [2:0]           delta;

    logic [2:0]           phase_n;
    logic                 valid_n;
    logic                 step_n;
    logic                 dir_n;
    logic                 half_n;
    logic [POS_WIDTH-1:0] pos_add;
    logic [POS_WIDTH-1:0] pos_n;
    logic                 ill_set;
    logic                 skip_set;
    logic                 err_ill_n;
    logic                 err_skip_n;
    logic                 stalled_n;

    // Stage 1: register the raw driver lines as {A,B,C,D,INH1,INH2}
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pat_q <= 6'b000000;
        end else begin
            pat_q <= {A, B, C, D, INH1, INH2};
        end
    end

    always_comb begin
        legal = 1'b1;
        idx   = 3'd0;
        case (pat_q)
            6'b010111: idx = 3'd0;
            6'b000110: idx = 3'd1;
            6'b101111: idx = 3'd2;
            6'b101010: idx = 3'd3;
            6'b101011: idx = 3'd4;
            6'b001001: idx = 3'd5;
            6'b011011: idx = 3'd6;
            6'b010010: idx = 3'd7;
            default:   legal = 1'b0;
        endcase
    end

    // 3-bit subtraction gives the forward distance modulo 8 directly
    assign delta = idx - prev_idx;

    always_comb begin
        state_n     = state;
        prev_idx_n  = prev_idx;
        stall_cnt_n = stall_cnt;
        phase_n     = PHASE;
        valid_n     = PHASE_VALID;
        step_n      = 1'b0;
        dir_n       = DIR;
        half_n      = HALF;
        pos_add     = '0;
        ill_set     = 1'b0;
        skip_set    = 1'b0;

        case (state)
            ST_ACQUIRE: begin
                stall_cnt_n = '0;
                if (legal) begin
                    prev_idx_n = idx;
                    phase_n    = idx;
                    valid_n    = 1'b1;
                    state_n    = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (!legal) begin
                    ill_set     = 1'b1;
                    valid_n     = 1'b0;
                    stall_cnt_n = '0;
                    state_n     = ST_ACQUIRE;
                end else begin
                    prev_idx_n = idx;
                    phase_n    = idx;
                    case (delta)
                        3'd1: begin
                            step_n  = 1'b1;
                            dir_n   = 1'b1;
                            half_n  = 1'b1;
                            pos_add = POS_WIDTH'(1);
                        end
                        3'd2: begin
                            step_n  = 1'b1;
                            dir_n   = 1'b1;
                            half_n  = 1'b0;
                            pos_add = POS_WIDTH'(2);
                        end
                        3'd7: begin
                            step_n  = 1'b1;
                            dir_n   = 1'b0;
                            half_n  = 1'b1;
                            pos_add = {POS_WIDTH{1'b1}};
                        end
                        3'd6: begin
                            step_n  = 1'b1;
                            dir_n   = 1'b0;
                            half_n  = 1'b0;
                            pos_add = {{(POS_WIDTH-1){1'b1}}, 1'b0};
                        end
                        3'd3, 3'd4, 3'd5: begin
                            skip_set = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                    if (step_n) begin
                        stall_cnt_n = '0;
                    end else if (stall_cnt != STALL_MAX) begin
                        stall_cnt_n = stall_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_ACQUIRE;
            end
        endcase

        // A clear request overrides any step landing in the same cycle
        pos_n      = CLR_POS ? '0 : POSITION + pos_add;
        err_ill_n  = (ERR_ILLEGAL & ~ERR_CLR) | ill_set;
        err_skip_n = (ERR_SKIP & ~ERR_CLR) | skip_set;
        stalled_n  = (stall_cnt_n == STALL_MAX);
    end

    // Stage 2: FSM state and all outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_ACQUIRE;
            prev_idx    <= 3'd0;
            stall_cnt   <= '0;
            PHASE       <= 3'd0;
            PHASE_VALID <= 1'b0;
            STEP        <= 1'b0;
            DIR         <= 1'b0;
            HALF        <= 1'b0;
            POSITION    <= '0;
            ERR_ILLEGAL <= 1'b0;
            ERR_SKIP    <= 1'b0;
            STALLED     <= 1'b0;
        end else begin
            state       <= state_n;
            prev_idx    <= prev_idx_n;
            stall_cnt   <= stall_cnt_n;
            PHASE       <= phase_n;
            PHASE_VALID <= valid_n;
            STEP        <= step_n;
            DIR         <= dir_n;
            HALF        <= half_n;
            POSITION    <= pos_n;
            ERR_ILLEGAL <= err_ill_n;
            ERR_SKIP    <= err_skip_n;
            STALLED     <= stalled_n;
        end
    end

endmodule

// File: tb/tb_decodificador_fases_motor.sv
// Bench for the stepper phase monitor: directed scenarios plus randomized motion against a reference model.
module tb_decodificador_fases_motor;

    localparam int PW = 16;
    localparam int SL = 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0, INH1 = 1'b0, INH2 = 1'b0;
    logic          CLR_POS = 1'b0, ERR_CLR = 1'b0;
    logic [2:0]    PHASE;
    logic          PHASE_VALID, STEP, DIR, HALF;
    logic [PW-1:0] POSITION;
    logic          ERR_ILLEGAL, ERR_SKIP, STALLED;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    decodificador_fases_motor #(.POS_WIDTH(PW), .STALL_LIMIT(SL)) dut (
        .CLK(CLK), .RESET(RESET),
        .A(A), .B(B), .C(C), .D(D), .INH1(INH1), .INH2(INH2),
        .CLR_POS(CLR_POS), .ERR_CLR(ERR_CLR),
        .PHASE(PHASE), .PHASE_VALID(PHASE_VALID), .STEP(STEP), .DIR(DIR), .HALF(HALF),
        .POSITION(POSITION), .ERR_ILLEGAL(ERR_ILLEGAL), .ERR_SKIP(ERR_SKIP), .STALLED(STALLED)
    );

    // ---------------- reference model ----------------
    bit         m_track, m_valid, m_step, m_dir, m_half, m_eill, m_eskip;
    int         m_prev, m_phase, m_pos, m_cnt;
    logic [5:0] m_pend;

    function automatic logic [5:0] pat_of(int i);
        case (i)
            0: return 6'b010111;
            1: return 6'b000110;
            2: return 6'b101111;
            3: return 6'b101010;
            4: return 6'b101011;
            5: return 6'b001001;
            6: return 6'b011011;
            7: return 6'b010010;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic int idx_of(logic [5:0] p);
        for (int i = 0; i < 8; i++) if (pat_of(i) == p) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_track = 0; m_valid = 0; m_step = 0; m_dir = 0; m_half = 0;
        m_eill = 0; m_eskip = 0; m_prev = 0; m_phase = 0; m_pos = 0; m_cnt = 0;
        m_pend = 6'b000000;
    endfunction

    // One stage-2 clock edge: consumes the sample captured on the previous edge
    function automatic void model_edge(bit clr, bit eclr);
        int i, d, dlt;
        bit nill, nskip;
        i = idx_of(m_pend);
        dlt = 0; nill = 0; nskip = 0; m_step = 0;
        if (!m_track) begin
            m_cnt = 0;
            if (i >= 0) begin
                m_prev = i; m_phase = i; m_valid = 1; m_track = 1;
            end
        end else if (i < 0) begin
            nill = 1; m_valid = 0; m_track = 0; m_cnt = 0;
        end else begin
            d = (i - m_prev + 8) % 8;
            if (d == 1 || d == 2) begin
                m_step = 1; m_dir = 1; m_half = (d == 1); dlt = d;
            end else if (d == 6 || d == 7) begin
                m_step = 1; m_dir = 0; m_half = (d == 7); dlt = d - 8;
            end else if (d != 0) begin
                nskip = 1;
            end
            m_prev = i; m_phase = i;
            if (m_step) m_cnt = 0;
            else if (m_cnt < SL) m_cnt++;
        end
        m_pos  = clr ? 0 : ((m_pos + dlt) & ((1 << PW) - 1));
        m_eill  = (m_eill && !eclr) || nill;
        m_eskip = (m_eskip && !eclr) || nskip;
    endfunction

    function automatic logic [PW+9:0] mdl_vec();
        logic [2:0]    ph;
        logic [PW-1:0] ps;
        ph = m_phase[2:0];
        ps = m_pos[PW-1:0];
        return {ph, m_valid, m_step, m_dir, m_half, ps, m_eill, m_eskip, (m_cnt == SL)};
    endfunction

    function automatic logic [PW+9:0] dut_vec();
        return {PHASE, PHASE_VALID, STEP, DIR, HALF, POSITION, ERR_ILLEGAL, ERR_SKIP, STALLED};
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic cyc(input logic [5:0] p, input bit clr, input bit eclr);
        {A, B, C, D, INH1, INH2} = p;
        CLR_POS = clr;
        ERR_CLR = eclr;
        @(posedge CLK);
        model_edge(clr, eclr);
        m_pend = p;
        #1;
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        model_reset();
        #1;
        RESET = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int k = 0; k < 6; k++) cyc(pat_of(k % 8), 0, 0);
        apply_reset();
        total++;
        if (dut_vec() !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
        end
        cyc(pat_of(4), 0, 0);
        total++;
        if (dut_vec() !== mdl_vec() || PHASE_VALID !== 1'b0) begin
            bad++; $display("FAIL reset_first_sample: got %h want %h", dut_vec(), mdl_vec());
        end
        cyc(pat_of(4), 0, 0);
        total++;
        if (PHASE_VALID !== 1'b1 || PHASE !== 3'd4 || STEP !== 1'b0) begin
            bad++; $display("FAIL reset_reacquire: got valid=%b phase=%0d step=%b want 1 4 0",
                            PHASE_VALID, PHASE, STEP);
        end
    endtask

    task automatic test_half_up();
        int steps = 0;
        apply_reset();
        for (int ph = 0; ph < 4; ph++) begin
            for (int j = 0; j < 4; j++) begin
                cyc(pat_of(ph), 0, 0);
                steps += STEP;
                total++;
                if (dut_vec() !== mdl_vec()) begin
                    bad++; $display("FAIL half_up_cycle: got %h want %h", dut_vec(), mdl_vec());
                end
                if (ph == 1) begin
                    total++;
                    if (STEP !== (j == 1)) begin
                        bad++; $display("FAIL half_up_latency: j=%0d got step=%b want %b", j, STEP, (j == 1));
                    end
                end
            end
        end
        total++;
        if (steps != 3 || DIR !== 1'b1 || HALF !== 1'b1 || POSITION !== 16'd3 || PHASE !== 3'd3) begin
            bad++; $display("FAIL half_up_final: got steps=%0d dir=%b half=%b pos=%h phase=%0d want 3 1 1 0003 3",
                            steps, DIR, HALF, POSITION, PHASE);
        end
    endtask

    task automatic test_full_down();
        int steps = 0;
        int seq[3] = '{0, 6, 4};
        apply_reset();
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < 4; j++) begin
                cyc(pat_of(seq[s]), 0, 0);
                steps += STEP;
                total++;
                if (dut_vec() !== mdl_vec()) begin
                    bad++; $display("FAIL full_down_cycle: got %h want %h", dut_vec(), mdl_vec());
                end
            end
        end
        total++;
        if (steps != 2 || DIR !== 1'b0 || HALF !== 1'b0 || POSITION !== 16'hFFFC) begin
            bad++; $display("FAIL full_down_final: got steps=%0d dir=%b half=%b pos=%h want 2 0 0 fffc",
                            steps, DIR, HALF, POSITION);
        end
    endtask

    task automatic test_skip();
        int steps = 0;
        apply_reset();
        repeat (4) cyc(pat_of(1), 0, 0);
        for (int j = 0; j < 4; j++) begin
            cyc(pat_of(5), 0, 0);
            steps += STEP;
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++; $display("FAIL skip_cycle: got %h want %h", dut_vec(), mdl_vec());
            end
        end
        total++;
        if (ERR_SKIP !== 1'b1 || steps != 0 || POSITION !== 16'd0 || PHASE !== 3'd5) begin
            bad++; $display("FAIL skip_flag: got skip=%b steps=%0d pos=%h phase=%0d want 1 0 0000 5",
                            ERR_SKIP, steps, POSITION, PHASE);
        end
        cyc(pat_of(5), 0, 1);
        total++;
        if (ERR_SKIP !== 1'b0) begin
            bad++; $display("FAIL skip_clear: got %b want 0", ERR_SKIP);
        end
        cyc(pat_of(0), 0, 0);
        cyc(pat_of(0), 0, 1);
        total++;
        if (ERR_SKIP !== 1'b1 || dut_vec() !== mdl_vec()) begin
            bad++; $display("FAIL skip_clear_vs_new: got skip=%b vec=%h want 1 %h", ERR_SKIP, dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_illegal();
        int steps = 0;
        apply_reset();
        repeat (3) cyc(pat_of(0), 0, 0);
        repeat (3) cyc(6'b111111, 0, 0);
        total++;
        if (ERR_ILLEGAL !== 1'b1 || PHASE_VALID !== 1'b0 || PHASE !== 3'd0) begin
            bad++; $display("FAIL illegal_flag: got ill=%b valid=%b phase=%0d want 1 0 0",
                            ERR_ILLEGAL, PHASE_VALID, PHASE);
        end
        for (int j = 0; j < 3; j++) begin
            cyc(pat_of(2), 0, 0);
            steps += STEP;
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++; $display("FAIL illegal_cycle: got %h want %h", dut_vec(), mdl_vec());
            end
        end
        total++;
        if (PHASE_VALID !== 1'b1 || PHASE !== 3'd2 || steps != 0 || ERR_ILLEGAL !== 1'b1) begin
            bad++; $display("FAIL illegal_reacquire: got valid=%b phase=%0d steps=%0d ill=%b want 1 2 0 1",
                            PHASE_VALID, PHASE, steps, ERR_ILLEGAL);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        for (int j = 0; j < 12; j++) begin
            cyc(pat_of(2), 0, 0);
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++; $display("FAIL stall_cycle: j=%0d got %h want %h", j, dut_vec(), mdl_vec());
            end
        end
        total++;
        if (STALLED !== 1'b1) begin
            bad++; $display("FAIL stall_assert: got %b want 1", STALLED);
        end
        for (int j = 0; j < 12; j++) begin
            cyc(pat_of(3), 0, 0);
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++; $display("FAIL stall_restart_cycle: j=%0d got %h want %h", j, dut_vec(), mdl_vec());
            end
            if (j == 2) begin
                total++;
                if (STALLED !== 1'b0) begin
                    bad++; $display("FAIL stall_release: got %b want 0", STALLED);
                end
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        repeat (2) cyc(pat_of(0), 0, 0);
        for (int k = 1; k <= 16384; k++) cyc(pat_of((8 - (2 * k) % 8) % 8), 0, 0);
        cyc(pat_of(0), 0, 0);
        total++;
        if (POSITION !== 16'h8000 || dut_vec() !== mdl_vec()) begin
            bad++; $display("FAIL wrap_down_run: got pos=%h want 8000", POSITION);
        end
        repeat (2) cyc(pat_of(7), 0, 0);
        total++;
        if (POSITION !== 16'h7FFF) begin
            bad++; $display("FAIL wrap_setup: got %h want 7fff", POSITION);
        end
        repeat (2) cyc(pat_of(0), 0, 0);
        total++;
        if (POSITION !== 16'h8000 || STEP !== 1'b1 || DIR !== 1'b1 || HALF !== 1'b1) begin
            bad++; $display("FAIL wrap_up: got pos=%h step=%b want 8000 1", POSITION, STEP);
        end
        repeat (2) cyc(pat_of(7), 0, 0);
        cyc(pat_of(0), 0, 0);
        cyc(pat_of(0), 1, 0);
        total++;
        if (POSITION !== 16'h0000 || STEP !== 1'b1 || DIR !== 1'b1 || HALF !== 1'b1) begin
            bad++; $display("FAIL wrap_clr_wins: got pos=%h step=%b dir=%b half=%b want 0000 1 1 1",
                            POSITION, STEP, DIR, HALF);
        end
    endtask

    task automatic test_random();
        int cur, r, hold, nxt;
        bit clr, eclr;
        logic [5:0] p;
        apply_reset();
        cur = 0;
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                do p = 6'($urandom); while (idx_of(p) >= 0);
            end else begin
                if (r < 14) nxt = (cur + $urandom_range(3, 5)) % 8;
                else begin
                    case ($urandom_range(0, 4))
                        0: nxt = cur;
                        1: nxt = (cur + 1) % 8;
                        2: nxt = (cur + 2) % 8;
                        3: nxt = (cur + 7) % 8;
                        default: nxt = (cur + 6) % 8;
                    endcase
                end
                cur = nxt;
                p = pat_of(cur);
            end
            if ($urandom_range(0, 299) == 0) apply_reset();
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) begin
                clr  = ($urandom_range(0, 49) == 0);
                eclr = ($urandom_range(0, 19) == 0);
                cyc(p, clr, eclr);
                total++;
                if (dut_vec() !== mdl_vec()) begin
                    bad++; $display("FAIL random_cycle: n=%0d got %h want %h", n, dut_vec(), mdl_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_half_up();
        test_full_down();
        test_skip();
        test_illegal();
        test_stall();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
